pool1_pingpong_scheduler: RTL and testbench

//  Schedules the two ping-pong feature-map banks between the conv1 producer and the pool1 consumer.
//  - Grants one bank at a time to the producer; a filled bank is handed to the consumer.
//  - Drives the start pulses and bank-select lines for both layers.
//  - Counts maps per frame and pulses frame_done once NUMBER_OF_IFM maps have been consumed.

---
 rtl/pool1_pingpong_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_pool1_pingpong_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool1_pingpong_scheduler.sv
//-----------------------------------------------------------------------------
// Module : pool1_pingpong_scheduler
// Purpose: Arbitrates two ping-pong feature-map banks (A=0, B=1) between the
//          conv1 producer and the pool1 consumer. One bank at a time is
//          granted to the producer; once full it is handed to the consumer.
//          Maps are counted per frame and o_frame_done pulses once
//          NUMBER_OF_IFM maps have been consumed.
//
// Parameters:
//   NUMBER_OF_IFM   maps per frame (1..255)
//   CNT_WIDTH       width of the map counters
//
// Ports:
//   i_clk             rising-edge clock
//   i_rst_n           asynchronous active-low reset
//   i_frame_start     1-cycle pulse starting a frame (ignored while busy)
//   o_producer_start  1-cycle pulse: conv1 may fill o_producer_bank
//   o_producer_bank   bank granted to the producer (0=A, 1=B)
//   i_producer_end    1-cycle pulse: granted producer bank is full
//   o_consumer_start  1-cycle pulse: pool1 may read o_consumer_bank
//   o_consumer_bank   bank granted to the consumer
//   i_consumer_end    1-cycle pulse: granted consumer bank is drained
//   o_bank_full       bit i set while bank i is FULL
//   o_maps_produced   maps completed by the producer this frame
//   o_maps_consumed   maps completed by the consumer this frame
//   o_busy            high while the frame FSM is not idle
//   o_frame_done      1-cycle pulse at end of frame
//   o_sched_err       sticky protocol-error flag
//
// Build option:
//   SCHED_ERR_EN      when defined, o_sched_err latches on spurious end pulses
//                     and on frame_start while busy; otherwise it is tied 0.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module pool1_pingpong_scheduler #(
    parameter int NUMBER_OF_IFM = 6,
    parameter int CNT_WIDTH     = $clog2(NUMBER_OF_IFM + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_start,
    output logic                 o_producer_start,
    output logic                 o_producer_bank,
    input  logic                 i_producer_end,
    output logic                 o_consumer_start,
    output logic                 o_consumer_bank,
    input  logic                 i_consumer_end,
    output logic [1:0]           o_bank_full,
    output logic [CNT_WIDTH-1:0] o_maps_produced,
    output logic [CNT_WIDTH-1:0] o_maps_consumed,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_sched_err
);

    localparam logic [CNT_WIDTH-1:0] LP_N    = CNT_WIDTH'(NUMBER_OF_IFM);
    localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(NUMBER_OF_IFM - 1);
    localparam logic [CNT_WIDTH-1:0] LP_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LP_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_t;

    state_t               r_state;
    bank_t                r_bank [2];
    logic                 r_wrPtr;
    logic                 r_rdPtr;
    logic                 r_prodActive;
    logic                 r_consActive;
    logic [CNT_WIDTH-1:0] r_mapsIssued;
    logic [CNT_WIDTH-1:0] r_mapsProduced;
    logic [CNT_WIDTH-1:0] r_mapsConsumed;
    logic                 r_producerStart;
    logic                 r_producerBank;
    logic                 r_consumerStart;
    logic                 r_consumerBank;
    logic                 r_busy;
    logic                 r_frameDone;

    logic w_prodGrant;
    logic w_consGrant;
    logic w_prodEndOk;
    logic w_consEndOk;
    logic w_frameAccept;

    // Grants look only at registered state, so a start pulse always trails
    // its enabling event by one extra cycle. Because the producer needs an
    // EMPTY bank and the consumer a FULL one, they can never share a bank.
    assign w_prodGrant   = (r_state == ST_RUN) && !r_prodActive &&
                           (r_bank[r_wrPtr] == BANK_EMPTY) && (r_mapsIssued < LP_N);
    assign w_consGrant   = (r_state == ST_RUN) && !r_consActive &&
                           (r_bank[r_rdPtr] == BANK_FULL);
    // End pulses without a matching active grant are dropped here.
    assign w_prodEndOk   = i_producer_end && r_prodActive;
    assign w_consEndOk   = i_consumer_end && r_consActive;
    assign w_frameAccept = i_frame_start && (r_state == ST_IDLE);

    // Frame FSM, bank state machines, pointers and counters in one place.
    // Same-cycle producer/consumer events always touch different banks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_bank[0]       <= BANK_EMPTY;
            r_bank[1]       <= BANK_EMPTY;
            r_wrPtr         <= 1'b0;
            r_rdPtr         <= 1'b0;
            r_prodActive    <= 1'b0;
            r_consActive    <= 1'b0;
            r_mapsIssued    <= LP_ZERO;
            r_mapsProduced  <= LP_ZERO;
            r_mapsConsumed  <= LP_ZERO;
            r_producerStart <= 1'b0;
            r_producerBank  <= 1'b0;
            r_consumerStart <= 1'b0;
            r_consumerBank  <= 1'b0;
            r_busy          <= 1'b0;
            r_frameDone     <= 1'b0;
        end else begin
            r_producerStart <= 1'b0;
            r_consumerStart <= 1'b0;

            if (w_prodEndOk) begin
                r_bank[r_wrPtr] <= BANK_FULL;
                r_wrPtr         <= ~r_wrPtr;
                r_prodActive    <= 1'b0;
                if (r_mapsProduced < LP_N) begin
                    r_mapsProduced <= r_mapsProduced + LP_ONE;
                end
            end

            if (w_consEndOk) begin
                r_bank[r_rdPtr] <= BANK_EMPTY;
                r_rdPtr         <= ~r_rdPtr;
                r_consActive    <= 1'b0;
                if (r_mapsConsumed < LP_N) begin
                    r_mapsConsumed <= r_mapsConsumed + LP_ONE;
                end
            end

            if (w_prodGrant) begin
                r_producerStart <= 1'b1;
                r_producerBank  <= r_wrPtr;
                r_bank[r_wrPtr] <= BANK_FILLING;
                r_prodActive    <= 1'b1;
                r_mapsIssued    <= r_mapsIssued + LP_ONE;
            end

            if (w_consGrant) begin
                r_consumerStart <= 1'b1;
                r_consumerBank  <= r_rdPtr;
                r_bank[r_rdPtr] <= BANK_DRAINING;
                r_consActive    <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_frameAccept) begin
                        r_state        <= ST_RUN;
                        r_busy         <= 1'b1;
                        r_wrPtr        <= 1'b0;
                        r_rdPtr        <= 1'b0;
                        r_mapsIssued   <= LP_ZERO;
                        r_mapsProduced <= LP_ZERO;
                        r_mapsConsumed <= LP_ZERO;
                    end
                end
                ST_RUN: begin
                    // Leave RUN on the same edge the last map is counted.
                    if (w_consEndOk && (r_mapsConsumed == LP_LAST)) begin
                        r_state     <= ST_DONE;
                        r_frameDone <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_frameDone <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_frameDone <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCHED_ERR_EN
    logic r_schedErr;
    logic w_errEvent;

    assign w_errEvent = (i_producer_end && !r_prodActive) ||
                        (i_consumer_end && !r_consActive) ||
                        (i_frame_start && (r_state != ST_IDLE));

    // Sticky error; a new error in the accepting cycle still wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_schedErr <= 1'b0;
        end else if (w_errEvent) begin
            r_schedErr <= 1'b1;
        end else if (w_frameAccept) begin
            r_schedErr <= 1'b0;
        end
    end

    assign o_sched_err = r_schedErr;
`else
    assign o_sched_err = 1'b0;
`endif

    assign o_producer_start = r_producerStart;
    assign o_producer_bank  = r_producerBank;
    assign o_consumer_start = r_consumerStart;
    assign o_consumer_bank  = r_consumerBank;
    assign o_bank_full      = {r_bank[1] == BANK_FULL, r_bank[0] == BANK_FULL};
    assign o_maps_produced  = r_mapsProduced;
    assign o_maps_consumed  = r_mapsConsumed;
    assign o_busy           = r_busy;
    assign o_frame_done     = r_frameDone;

endmodule

// File: tb/tb_pool1_pingpong_scheduler.sv
`timescale 1ns/1ps
module tb_pool1_pingpong_scheduler;

`ifdef SCHED_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rstN;
    logic frameStart;
    logic manualPe;
    logic manualCe;
    logic autoPe;
    logic autoCe;
    logic producerEnd;
    logic consumerEnd;

    logic       ps2, pb2, cs2, cb2, busy2, done2, err2;
    logic [1:0] full2, prod2, cons2;
    logic       ps6, pb6, cs6, cb6, busy6, done6, err6;
    logic [1:0] full6;
    logic [2:0] prod6, cons6;

    int compCount;
    int errCount;
    int psCount6;
    int doneCycles6;
    int prodCnt;
    int consCnt;
    bit sbEnable;
    bit autoResp;
    logic prodQ[$];
    logic consQ[$];

    typedef struct {
        string      name;
        logic       fs;
        logic       pe;
        logic       ce;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[11];

    assign producerEnd = manualPe | autoPe;
    assign consumerEnd = manualCe | autoCe;

    // Small instance used for the two-map frame table.
    pool1_pingpong_scheduler #(.NUMBER_OF_IFM(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rstN), .i_frame_start(frameStart),
        .o_producer_start(ps2), .o_producer_bank(pb2), .i_producer_end(producerEnd),
        .o_consumer_start(cs2), .o_consumer_bank(cb2), .i_consumer_end(consumerEnd),
        .o_bank_full(full2), .o_maps_produced(prod2), .o_maps_consumed(cons2),
        .o_busy(busy2), .o_frame_done(done2), .o_sched_err(err2)
    );

    // Default six-map instance checked by the scoreboard.
    pool1_pingpong_scheduler #(.NUMBER_OF_IFM(6)) u_dut6 (
        .i_clk(clk), .i_rst_n(rstN), .i_frame_start(frameStart),
        .o_producer_start(ps6), .o_producer_bank(pb6), .i_producer_end(producerEnd),
        .o_consumer_start(cs6), .o_consumer_bank(cb6), .i_consumer_end(consumerEnd),
        .o_bank_full(full6), .o_maps_produced(prod6), .o_maps_consumed(cons6),
        .o_busy(busy6), .o_frame_done(done6), .o_sched_err(err6)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge sample them, then clear.
    task automatic applyStimulus(input logic fs, input logic pe, input logic ce);
        frameStart = fs;
        manualPe   = pe;
        manualCe   = ce;
        @(posedge clk);
        #1;
        frameStart = 1'b0;
        manualPe   = 1'b0;
        manualCe   = 1'b0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic waitFrameDone(input string name, input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done6) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    function automatic vec_t mkVec(input string name, input logic fs, input logic pe,
                                   input logic ce, input logic ps, input logic pb,
                                   input logic cs, input logic cb, input logic [1:0] full,
                                   input logic busy, input logic done,
                                   input logic [1:0] prod, input logic [1:0] cons);
        vec_t v;
        v.name = name;
        v.fs   = fs;
        v.pe   = pe;
        v.ce   = ce;
        v.exp  = {ps, pb, cs, cb, full, busy, done, prod, cons};
        return v;
    endfunction

    function automatic logic [11:0] dut2Outputs();
        return {ps2, pb2, cs2, cb2, full2, busy2, done2, prod2, cons2};
    endfunction

    // Main sequence: the monitor/responder and the watchdog run as forked
    // branches of this block so every counter has a single owner.
    initial begin
        compCount   = 0;
        errCount    = 0;
        psCount6    = 0;
        doneCycles6 = 0;
        prodCnt     = 0;
        consCnt     = 0;
        sbEnable    = 1'b0;
        autoResp    = 1'b0;
        rstN        = 1'b0;
        frameStart  = 1'b0;
        manualPe    = 1'b0;
        manualCe    = 1'b0;
        autoPe      = 1'b0;
        autoCe      = 1'b0;

        fork
            begin
                #200000;
                $display("[TB] FAIL watchdog: simulation time limit reached");
                $fatal(1, "[TB] watchdog expired");
            end
            forever begin
                @(negedge clk);
                // Scoreboard: compare each observed grant with the queue.
                if (ps6 === 1'b1) begin
                    psCount6++;
                    if (sbEnable) begin
                        checkOutput("producer_start expected", 32'(prodQ.size() != 0), 32'd1);
                        if (prodQ.size() != 0) checkOutput("producer_bank", 32'(pb6), 32'(prodQ.pop_front()));
                    end
                end
                if (cs6 === 1'b1 && sbEnable) begin
                    checkOutput("consumer_start expected", 32'(consQ.size() != 0), 32'd1);
                    if (consQ.size() != 0) checkOutput("consumer_bank", 32'(cb6), 32'(consQ.pop_front()));
                end
                if (done6 === 1'b1) doneCycles6++;
                // Responder: fake conv1/pool1 that finish after a fixed delay.
                autoPe = 1'b0;
                autoCe = 1'b0;
                if (prodCnt != 0) begin
                    prodCnt--;
                    if (prodCnt == 0) autoPe = 1'b1;
                end
                if (consCnt != 0) begin
                    consCnt--;
                    if (consCnt == 0) autoCe = 1'b1;
                end
                if (autoResp && ps6 === 1'b1) prodCnt = 2;
                if (autoResp && cs6 === 1'b1) consCnt = 4;
                if (!autoResp) begin
                    prodCnt = 0;
                    consCnt = 0;
                end
            end
        join_none

        // T1/T3 table for the two-map instance, one row per clock edge.
        vecs[0]  = mkVec("T1 frame_start",        1,0,0, 0,0,0,0, 2'b00, 1,0, 2'd0,2'd0);
        vecs[1]  = mkVec("T1 producer grant",     0,0,0, 1,0,0,0, 2'b00, 1,0, 2'd0,2'd0);
        vecs[2]  = mkVec("T1 producer filling",   0,0,0, 0,0,0,0, 2'b00, 1,0, 2'd0,2'd0);
        vecs[3]  = mkVec("T1 producer_end",       0,1,0, 0,0,0,0, 2'b01, 1,0, 2'd1,2'd0);
        vecs[4]  = mkVec("T1 dual grant",         0,0,0, 1,1,1,0, 2'b00, 1,0, 2'd1,2'd0);
        vecs[5]  = mkVec("T1 both active",        0,0,0, 0,1,0,0, 2'b00, 1,0, 2'd1,2'd0);
        vecs[6]  = mkVec("T3 simultaneous ends",  0,1,1, 0,1,0,0, 2'b10, 1,0, 2'd2,2'd1);
        vecs[7]  = mkVec("T1 consumer grant b1",  0,0,0, 0,1,1,1, 2'b00, 1,0, 2'd2,2'd1);
        vecs[8]  = mkVec("T1 last consumer_end",  0,0,1, 0,1,0,1, 2'b00, 1,1, 2'd2,2'd2);
        vecs[9]  = mkVec("T1 back to idle",       0,0,0, 0,1,0,1, 2'b00, 0,0, 2'd2,2'd2);
        vecs[10] = mkVec("T1 idle hold",          0,0,0, 0,1,0,1, 2'b00, 0,0, 2'd2,2'd2);

        doReset();
        checkOutput("reset state dut2", 32'({dut2Outputs(), err2}), 32'd0);
        checkOutput("reset state dut6",
                    32'({ps6, pb6, cs6, cb6, full6, busy6, done6, prod6, cons6, err6}), 32'd0);

        $display("[TB] T1 two-map frame table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].fs, vecs[i].pe, vecs[i].ce);
            checkOutput(vecs[i].name, 32'(dut2Outputs()), 32'(vecs[i].exp));
        end

        $display("[TB] T2 consumer stalls, producer must wait");
        doReset();
        sbEnable = 1'b1;
        psCount6 = 0;
        prodQ.push_back(1'b0);
        applyStimulus(1, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("T2 producer_start 2 cycles after frame_start", 32'({ps6, pb6}), 32'b10);
        applyStimulus(0, 1, 0);
        consQ.push_back(1'b0);
        prodQ.push_back(1'b1);
        applyStimulus(0, 0, 0);
        checkOutput("T2 dual grant", 32'({ps6, pb6, cs6, cb6}), 32'b1110);
        applyStimulus(0, 1, 0);
        repeat (4) applyStimulus(0, 0, 0);
        checkOutput("T2 bank_full while stalled", 32'(full6), 32'b10);
        checkOutput("T2 producer stalled", 32'(psCount6), 32'd2);
        checkOutput("T2 counters", 32'({prod6, cons6}), 32'({3'd2, 3'd0}));
        prodQ.push_back(1'b0);
        consQ.push_back(1'b1);
        applyStimulus(0, 0, 1);
        checkOutput("T2 no early grant", 32'({ps6, cs6}), 32'b00);
        applyStimulus(0, 0, 0);
        checkOutput("T2 grants after consumer_end", 32'({ps6, pb6, cs6, cb6}), 32'b1011);

        $display("[TB] T3 simultaneous producer_end and consumer_end");
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 1);
        checkOutput("T3 both counters step", 32'({prod6, cons6}), 32'({3'd3, 3'd2}));
        checkOutput("T3 bank_full", 32'(full6), 32'b01);
        prodQ.push_back(1'b1);
        consQ.push_back(1'b0);
        applyStimulus(0, 0, 0);
        checkOutput("T3 toggled grants", 32'({ps6, pb6, cs6, cb6}), 32'b1110);
        @(negedge clk);
        #1;
        checkOutput("T3 scoreboard drained", 32'(prodQ.size() + consQ.size()), 32'd0);

        $display("[TB] T5 asynchronous reset mid-frame");
        doneCycles6 = 0;
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("T5 outputs cleared immediately",
                    32'({ps6, pb6, cs6, cb6, full6, busy6, done6, prod6, cons6, err6}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        repeat (5) applyStimulus(0, 0, 0);
        checkOutput("T5 no frame_done from aborted frame", 32'(doneCycles6), 32'd0);

        $display("[TB] T6 back-to-back six-map frames");
        autoResp = 1'b1;
        for (int f = 0; f < 2; f++) begin
            psCount6    = 0;
            doneCycles6 = 0;
            for (int i = 0; i < 6; i++) begin
                prodQ.push_back(1'(i % 2));
                consQ.push_back(1'(i % 2));
            end
            applyStimulus(1, 0, 0);
            checkOutput("T6 counters cleared at frame_start", 32'({busy6, prod6, cons6}),
                        32'({1'b1, 3'd0, 3'd0}));
            waitFrameDone("T6 frame_done seen", 400);
            checkOutput("T6 counters at frame_done", 32'({prod6, cons6}), 32'({3'd6, 3'd6}));
            repeat (4) applyStimulus(0, 0, 0);
            checkOutput("T6 six producer_starts", 32'(psCount6), 32'd6);
            checkOutput("T6 one-cycle frame_done", 32'(doneCycles6), 32'd1);
            checkOutput("T6 scoreboard drained", 32'(prodQ.size() + consQ.size()), 32'd0);
            checkOutput("T6 counters hold in idle", 32'({busy6, prod6, cons6}),
                        32'({1'b0, 3'd6, 3'd6}));
        end
        autoResp = 1'b0;

        $display("[TB] T4 spurious end and frame_start while busy");
        applyStimulus(0, 0, 1);
        checkOutput("T4 spurious end error flag", 32'(err6), 32'(ERR_EN));
        checkOutput("T4 spurious end ignored", 32'({busy6, cons6}), 32'({1'b0, 3'd6}));
        prodQ.push_back(1'b0);
        applyStimulus(1, 0, 0);
        checkOutput("T4 accepted frame_start clears error", 32'(err6), 32'd0);
        applyStimulus(1, 0, 0);
        checkOutput("T4 busy frame_start error flag", 32'(err6), 32'(ERR_EN));
        checkOutput("T4 busy frame_start ignored", 32'({busy6, prod6, cons6}),
                    32'({1'b1, 3'd0, 3'd0}));
        repeat (3) applyStimulus(0, 0, 0);
        checkOutput("T4 error sticky", 32'(err6), 32'(ERR_EN));
        @(negedge clk);
        #1;
        checkOutput("T4 scoreboard drained", 32'(prodQ.size() + consQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
